ping_pong_ctrl: RTL and testbench

Bank-select controller for a two-bank (ping/pong) input buffer between a tile loader (writer) and the compute engine (reader). It tracks which bank the loader is filling and which bank the engine is consuming, plus a full flag per bank. It asserts inbuffer_enout while the reader's bank holds a complete tile. It sequences one layer, from Ctrl_start until the last tile has been both written and consumed.

---
 rtl/ping_pong_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ping_pong_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_ctrl.sv
// ping_pong_ctrl: bank-select controller for a two-bank (ping/pong) input
// buffer between a tile loader (writer) and the compute engine (reader).
// Tracks the loader's bank, the engine's bank and a full flag per bank, and
// sequences one layer from Ctrl_start until the last tile is written and
// consumed (IDLE -> RUN -> DRAIN -> DONE -> IDLE).
//
// Optional build macro PING_PONG_ERR_EN adds:
//   err_sticky : set on an overflow write_finish or underflow done_tile while
//                in RUN/DRAIN; cleared by rst or an accepted Ctrl_start.
//   busy       : high whenever the controller is not in IDLE.
module ping_pong_ctrl (
  input  logic clki,
  input  logic rst,
  input  logic Ctrl_start,
  input  logic done_tile,
  input  logic last_tile,
  input  logic write_finish,
  output logic ping_pong_write,
  output logic ping_pong_read,
  output logic inbuffer_enout
`ifdef PING_PONG_ERR_EN
  ,
  output logic err_sticky,
  output logic busy
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [1:0] r_full;
  logic       r_wr;
  logic       r_rd;
  logic       r_enout;

  state_t     w_state_nxt;
  logic [1:0] w_full_nxt;
  logic       w_wr_nxt;
  logic       w_rd_nxt;
  logic       w_wr_ok;
  logic       w_rd_ok;
  logic       w_enout_nxt;

`ifdef PING_PONG_ERR_EN
  logic r_err;
  logic r_busy;
  logic w_ovf;
  logic w_unf;
`endif

  // Next-state, next-flag and next-output computation for one clock edge.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_state_nxt = r_state;
    w_full_nxt  = r_full;
    w_wr_nxt    = r_wr;
    w_rd_nxt    = r_rd;
    w_wr_ok     = 1'b0;
    w_rd_ok     = 1'b0;
`ifdef PING_PONG_ERR_EN
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        // write_finish / done_tile are ignored until a layer is started.
        if (Ctrl_start) begin
          w_state_nxt = S_RUN;
          w_full_nxt  = 2'b00;
          w_wr_nxt    = 1'b0;
          w_rd_nxt    = 1'b0;
        end
      end

      S_RUN, S_DRAIN: begin
        // Both events are judged against the pre-edge flags. When wr==rd the
        // shared bank is either full (write overflows, read proceeds) or
        // empty (read underflows, write proceeds), so they never collide.
        w_wr_ok = (r_state == S_RUN) && write_finish && !r_full[r_wr];
        w_rd_ok = done_tile && r_full[r_rd];
`ifdef PING_PONG_ERR_EN
        // A write_finish into a full bank is flagged even while draining.
        w_ovf   = write_finish && r_full[r_wr];
        w_unf   = done_tile && !r_full[r_rd];
`endif
        if (w_wr_ok) begin
          w_full_nxt[r_wr] = 1'b1;
          w_wr_nxt         = ~r_wr;
        end
        if (w_rd_ok) begin
          w_full_nxt[r_rd] = 1'b0;
          w_rd_nxt         = ~r_rd;
        end
        if (r_state == S_RUN) begin
          if (w_wr_ok && last_tile) begin
            w_state_nxt = S_DRAIN;
          end
        end else if (w_full_nxt == 2'b00) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // Bank selects return to 0 as the controller re-enters IDLE.
        w_state_nxt = S_IDLE;
        w_wr_nxt    = 1'b0;
        w_rd_nxt    = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_full_nxt  = 2'b00;
        w_wr_nxt    = 1'b0;
        w_rd_nxt    = 1'b0;
      end
    endcase

    w_enout_nxt = ((w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN)) &&
                  w_full_nxt[w_rd_nxt];
  end

  // State, flags and registered outputs; synchronous active-high reset.
  always_ff @(posedge clki) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= S_IDLE;
      r_full  <= 2'b00;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_enout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= w_full_nxt;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_enout <= w_enout_nxt;
    end
  end

`ifdef PING_PONG_ERR_EN
  // Sticky error flag and registered busy indication.
  always_ff @(posedge clki) begin
    if (rst) begin
      r_err  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && Ctrl_start) begin
        r_err <= 1'b0;
      end else if (w_ovf || w_unf) begin
        r_err <= 1'b1;
      end
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign err_sticky = r_err;
  assign busy       = r_busy;
`endif

  assign ping_pong_write = r_wr;
  assign ping_pong_read  = r_rd;
  assign inbuffer_enout  = r_enout;

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Testbench for ping_pong_ctrl. A driver applies directed and random stimulus
// on the falling edge and pushes the expected post-edge outputs into a
// scoreboard queue; a monitor pops and compares shortly after each rising
// edge. The reference model tracks tiles written and tiles consumed as plain
// counters: occupancy = written - read, the loader's bank is written mod 2 and
// the reader's bank is read mod 2.
module tb_ping_pong_ctrl;

  logic clki;
  logic rst;
  logic Ctrl_start;
  logic done_tile;
  logic last_tile;
  logic write_finish;
  logic ping_pong_write;
  logic ping_pong_read;
  logic inbuffer_enout;
`ifdef PING_PONG_ERR_EN
  logic err_sticky;
  logic busy;
`endif

  ping_pong_ctrl dut (
    .clki            (clki),
    .rst             (rst),
    .Ctrl_start      (Ctrl_start),
    .done_tile       (done_tile),
    .last_tile       (last_tile),
    .write_finish    (write_finish),
    .ping_pong_write (ping_pong_write),
    .ping_pong_read  (ping_pong_read),
    .inbuffer_enout  (inbuffer_enout)
`ifdef PING_PONG_ERR_EN
    ,
    .err_sticky      (err_sticky),
    .busy            (busy)
`endif
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  typedef struct packed {
    logic wr;
    logic rd;
    logic en;
    logic err;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: layer phase plus tile counters.
  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  int   m_phase   = PH_IDLE;
  int   m_written = 0;
  int   m_read    = 0;
  logic m_err     = 1'b0;

  task automatic model_step(input logic r, input logic st, input logic wf,
                            input logic dt, input logic lt);
    int   occ;
    logic w_acc;
    logic r_acc;
    exp_t e;
    if (r) begin
      m_phase   = PH_IDLE;
      m_written = 0;
      m_read    = 0;
      m_err     = 1'b0;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          if (st) begin
            m_phase   = PH_RUN;
            m_written = 0;
            m_read    = 0;
            m_err     = 1'b0;
          end
        end
        PH_RUN, PH_DRAIN: begin
          occ   = m_written - m_read;
          w_acc = (m_phase == PH_RUN) && wf && (occ < 2);
          r_acc = dt && (occ > 0);
          if ((wf && occ == 2) || (dt && occ == 0)) m_err = 1'b1;
          if (w_acc) m_written++;
          if (r_acc) m_read++;
          if (m_phase == PH_RUN) begin
            if (w_acc && lt) m_phase = PH_DRAIN;
          end else if (m_written == m_read) begin
            m_phase = PH_DONE;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
    if (m_phase == PH_IDLE) begin
      e.wr = 1'b0;
      e.rd = 1'b0;
    end else begin
      e.wr = m_written[0];
      e.rd = m_read[0];
    end
    e.en   = ((m_phase == PH_RUN) || (m_phase == PH_DRAIN)) &&
             (m_written - m_read > 0);
    e.err  = m_err;
    e.busy = (m_phase != PH_IDLE);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge and queue its expectation.
  task automatic cyc(input logic r, input logic st, input logic wf,
                     input logic dt, input logic lt);
    @(negedge clki);
    rst          = r;
    Ctrl_start   = st;
    write_finish = wf;
    done_tile    = dt;
    last_tile    = lt;
    model_step(r, st, wf, dt, lt);
  endtask

  // Monitor: compare registered outputs 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clki);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (ping_pong_write !== e.wr || ping_pong_read !== e.rd ||
            inbuffer_enout !== e.en) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got wr=%b rd=%b en=%b, expected wr=%b rd=%b en=%b",
                   $time, ping_pong_write, ping_pong_read, inbuffer_enout,
                   e.wr, e.rd, e.en);
        end
`ifdef PING_PONG_ERR_EN
        n_tests++;
        if (err_sticky !== e.err || busy !== e.busy) begin
          n_fail++;
          $display("FAIL err_busy t=%0t: got err=%b busy=%b, expected err=%b busy=%b",
                   $time, err_sticky, busy, e.err, e.busy);
        end
`endif
      end
    end
  end

  initial begin
    int wait_cycles;
    rst          = 1'b1;
    Ctrl_start   = 1'b0;
    write_finish = 1'b0;
    done_tile    = 1'b0;
    last_tile    = 1'b0;

    // Reset, start, then a first tile after 10 cycles.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);   // wr 0->1, enout 0->1
    cyc(0, 0, 0, 1, 0);   // rd -> 1, enout 0
    cyc(0, 0, 1, 0, 0);   // full[1], wr -> 0, enout 1
    // Writer ahead, overflow, then reads.
    cyc(0, 0, 1, 0, 0);   // fills bank0
    cyc(0, 0, 1, 0, 0);   // overflow, ignored
    cyc(0, 0, 0, 1, 0);   // frees bank1, enout stays 1
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);   // underflow, ignored
    // Simultaneous write and read with wr != rd.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0);   // start outside IDLE ignored
    // Last tile, drain, done, idle.
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);   // ignored in DRAIN
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);   // ignored in IDLE
    // Reset mid-RUN with both banks full, then restart.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 4) == 0));
    end
    cyc(0, 0, 0, 0, 0);

    // Bounded wait for the monitor to drain the scoreboard.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clki);
      wait_cycles++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
